// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU decoder with iterative multiply/divide unit.
// The divider-related enum member exists only when ALU_CTRL_MDU_DIV_EN is defined.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

`ifdef ALU_CTRL_MDU_DIV_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } mdu_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_FIX  = 2'b11
    } mdu_state_t;
`endif

    // True for the functs that launch a multi-cycle operation in this build.
    function automatic logic is_md_funct(input logic [5:0] f);
        logic hit;
        hit = (f == F_MULT) || (f == F_MULTU);
`ifdef ALU_CTRL_MDU_DIV_EN
        hit = hit || (f == F_DIV) || (f == F_DIVU);
`endif
        return hit;
    endfunction

endpackage

// File: rtl/alu_ctrl_mdu_iter.sv
// Iterative datapath: shift-add multiplier and (with ALU_CTRL_MDU_DIV_EN) restoring
// divider sharing one 2*WIDTH accumulator, plus the final sign correction.
module mdu_iter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic             run,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             cnt_last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   b_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               neg_q_r;
    logic [WIDTH-1:0]   rs_mag_s;
    logic [WIDTH-1:0]   rt_mag_s;
    logic [WIDTH-1:0]   acc_init_s;
    logic [WIDTH-1:0]   b_init_s;
    logic [WIDTH:0]     mul_sum_s;

`ifdef ALU_CTRL_MDU_DIV_EN
    logic               neg_r_r;
    logic               is_div_r;
    logic               dz_r;
    logic [WIDTH-1:0]   rs_raw_r;
    logic [WIDTH:0]     div_shift_s;
    logic               div_ge_s;
`else
    logic               unused_op_div_s;
    assign unused_op_div_s = op_div;
`endif

    // Operand magnitudes for signed ops and the accumulator/second-operand split.
    always_comb begin
        if (op_signed && rs_val[WIDTH-1]) begin
            rs_mag_s = -rs_val;
        end else begin
            rs_mag_s = rs_val;
        end
        if (op_signed && rt_val[WIDTH-1]) begin
            rt_mag_s = -rt_val;
        end else begin
            rt_mag_s = rt_val;
        end
`ifdef ALU_CTRL_MDU_DIV_EN
        if (op_div) begin
            acc_init_s = rs_mag_s;
            b_init_s   = rt_mag_s;
        end else begin
            acc_init_s = rt_mag_s;
            b_init_s   = rs_mag_s;
        end
`else
        acc_init_s = rt_mag_s;
        b_init_s   = rs_mag_s;
`endif
    end

    // One iteration: multiplier bit add-and-shift, or one restoring-division step.
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc_r[0] ? b_r : {WIDTH{1'b0}})};
`ifdef ALU_CTRL_MDU_DIV_EN
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_ge_s    = div_shift_s >= {1'b0, b_r};
        if (is_div_r && div_ge_s) begin
            acc_next_s = {div_shift_s[WIDTH-1:0] - b_r, acc_r[WIDTH-2:0], 1'b1};
        end else if (is_div_r) begin
            acc_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end else begin
            acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
`else
        acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
`endif
    end

    // Operand latch on start, then one step per running cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            b_r      <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            neg_q_r  <= 1'b0;
`ifdef ALU_CTRL_MDU_DIV_EN
            neg_r_r  <= 1'b0;
            is_div_r <= 1'b0;
            dz_r     <= 1'b0;
            rs_raw_r <= {WIDTH{1'b0}};
`endif
        end else if (start) begin
            acc_r    <= {{WIDTH{1'b0}}, acc_init_s};
            b_r      <= b_init_s;
            cnt_r    <= CNT_W'(WIDTH);
            neg_q_r  <= op_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
`ifdef ALU_CTRL_MDU_DIV_EN
            neg_r_r  <= op_signed & rs_val[WIDTH-1];
            is_div_r <= op_div;
            dz_r     <= (rt_val == {WIDTH{1'b0}});
            rs_raw_r <= rs_val;
`endif
        end else if (run) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r - CNT_W'(1);
        end
    end

    assign cnt_last = (cnt_r == CNT_W'(1));

    // Sign correction of the finished accumulator into HI/LO form.
    always_comb begin
        if (neg_q_r) begin
            prod_s = -acc_r;
        end else begin
            prod_s = acc_r;
        end
`ifdef ALU_CTRL_MDU_DIV_EN
        if (is_div_r && dz_r) begin
            res_lo = {WIDTH{1'b1}};
            res_hi = rs_raw_r;
        end else if (is_div_r) begin
            res_lo = neg_q_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
            res_hi = neg_r_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
        end else begin
            res_lo = prod_s[WIDTH-1:0];
            res_hi = prod_s[2*WIDTH-1:WIDTH];
        end
`else
        res_lo = prod_s[WIDTH-1:0];
        res_hi = prod_s[2*WIDTH-1:WIDTH];
`endif
    end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU operation decoder plus iterative MDU control and HI/LO registers.
// Divide support is compiled in only when ALU_CTRL_MDU_DIV_EN is defined.
module alu_ctrl_mdu
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       alu_control,
    output logic             hilo_wb,
    output logic [WIDTH-1:0] hilo_out,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t       state_r;
    logic             busy_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             rtype_s;
    logic             idle_s;
    logic             start_s;
    logic             op_div_s;
    logic             op_signed_s;
    logic             run_s;
    logic             mthi_s;
    logic             mtlo_s;
    logic             cnt_last_s;
    logic [WIDTH-1:0] res_hi_s;
    logic [WIDTH-1:0] res_lo_s;

    // ALUOp/funct decode to the ALU operation code.
    always_comb begin
        alu_control = ALU_AND;
        case (ALUOp)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    F_ADD:   alu_control = ALU_ADD;
                    F_SUB:   alu_control = ALU_SUB;
                    F_AND:   alu_control = ALU_AND;
                    F_OR:    alu_control = ALU_OR;
                    F_NOR:   alu_control = ALU_NOR;
                    F_SLT:   alu_control = ALU_SLT;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_AND;
        endcase
    end

    // Instruction qualification; MD launches and MT writes only happen while idle.
    always_comb begin
        rtype_s     = (ALUOp == ALUOP_RTYPE);
        idle_s      = (state_r == ST_IDLE);
        start_s     = valid & idle_s & rtype_s & is_md_funct(funct);
        op_div_s    = funct[1];
        op_signed_s = ~funct[0];
        mthi_s      = valid & idle_s & rtype_s & (funct == F_MTHI);
        mtlo_s      = valid & idle_s & rtype_s & (funct == F_MTLO);
`ifdef ALU_CTRL_MDU_DIV_EN
        run_s       = (state_r == ST_MUL) || (state_r == ST_DIV);
`else
        run_s       = (state_r == ST_MUL);
`endif
        hilo_wb     = rtype_s & ((funct == F_MFHI) || (funct == F_MFLO));
        if (rtype_s && (funct == F_MFHI)) begin
            hilo_out = hi_r;
        end else begin
            hilo_out = lo_r;
        end
    end

    mdu_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_s),
        .op_div    (op_div_s),
        .op_signed (op_signed_s),
        .run       (run_s),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .cnt_last  (cnt_last_s),
        .res_hi    (res_hi_s),
        .res_lo    (res_lo_s)
    );

    // MDU sequencing and HI/LO ownership; results land on the edge leaving FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
`ifdef ALU_CTRL_MDU_DIV_EN
                    if (start_s && op_div_s) begin
                        state_r <= ST_DIV;
                        busy_r  <= 1'b1;
                    end else if (start_s) begin
`else
                    if (start_s) begin
`endif
                        state_r <= ST_MUL;
                        busy_r  <= 1'b1;
                    end else if (mthi_s) begin
                        hi_r <= rs_val;
                    end else if (mtlo_s) begin
                        lo_r <= rs_val;
                    end
                end
                ST_MUL: begin
                    if (cnt_last_s) begin
                        state_r <= ST_FIX;
                    end
                end
`ifdef ALU_CTRL_MDU_DIV_EN
                ST_DIV: begin
                    if (cnt_last_s) begin
                        state_r <= ST_FIX;
                    end
                end
`endif
                ST_FIX: begin
                    hi_r    <= res_hi_s;
                    lo_r    <= res_lo_s;
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Self-checking bench for alu_ctrl_mdu: randomized decode and MDU operations
// against an arithmetic reference model; divide checks follow ALU_CTRL_MDU_DIV_EN.
module tb_alu_ctrl_mdu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid;
    logic [1:0]   aluop;
    logic [5:0]   funct;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic [3:0]   alu_control;
    logic         hilo_wb;
    logic [W-1:0] hilo_out;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           n_checks;
    int           n_fail;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;

    alu_ctrl_mdu #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid       (valid),
        .ALUOp       (aluop),
        .funct       (funct),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .alu_control (alu_control),
        .hilo_wb     (hilo_wb),
        .hilo_out    (hilo_out),
        .busy        (busy),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_alu(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'd0) return 4'd2;
        if (op == 2'd1) return 4'd6;
        if (op == 2'd2) begin
            case (f)
                6'd32:   return 4'd2;
                6'd34:   return 4'd6;
                6'd36:   return 4'd0;
                6'd37:   return 4'd1;
                6'd39:   return 4'd12;
                6'd42:   return 4'd7;
                default: return 4'd0;
            endcase
        end
        return 4'd0;
    endfunction

    function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        p = sa * sb;
        return 64'(p);
    endfunction

    // Returns {hi, lo}.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qv = 64'(q);
        rv = 64'(r);
        return {rv[31:0], qv[31:0]};
    endfunction

    task automatic idle_inputs();
        valid  = 1'b0;
        aluop  = 2'b00;
        funct  = 6'd0;
    endtask

    // Present an instruction for one cycle; returns at the negedge after its edge.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid  = 1'b1;
        aluop  = 2'b10;
        funct  = f;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic wait_idle(output int lat);
        lat = 0;
        while (busy === 1'b1 && lat < 200) begin
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
    endtask

    task automatic test_decode();
        logic [5:0] fl [8];
        logic [3:0] e;
        fl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd16, 6'd18};
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 0) begin
                aluop = 2'b00; funct = 6'($urandom);
            end else if (i == 1) begin
                aluop = 2'b10; funct = 6'd39;
            end else if (i == 2) begin
                aluop = 2'b11; funct = 6'd32;
            end else begin
                aluop = 2'($urandom);
                funct = ($urandom_range(0, 1) == 1) ? fl[$urandom_range(0, 7)] : 6'($urandom);
            end
            #1;
            e = ref_alu(aluop, funct);
            n_checks++;
            if (alu_control !== e) begin
                n_fail++;
                $display("FAIL decode: aluop=%b funct=%b got %b required %b", aluop, funct, alu_control, e);
            end
            n_checks++;
            if (hilo_wb !== (aluop == 2'd2 && (funct == 6'd16 || funct == 6'd18))) begin
                n_fail++;
                $display("FAIL hilo_wb: aluop=%b funct=%b got %b", aluop, funct, hilo_wb);
            end
        end
        idle_inputs();
    endtask

    task automatic run_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b, input logic chk_lat);
        int lat;
        logic [63:0] p;
        issue(sgn ? 6'd24 : 6'd25, a, b);
        wait_idle(lat);
        p = ref_mul(sgn, a, b);
        exp_hi = p[63:32];
        exp_lo = p[31:0];
        if (chk_lat) begin
            n_checks++;
            if (lat !== W + 1) begin
                n_fail++;
                $display("FAIL mul_latency: busy cycles %0d required %0d", lat, W + 1);
            end
        end
        n_checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            n_fail++;
            $display("FAIL mul_result: sgn=%b a=%h b=%h got %h_%h required %h_%h", sgn, a, b, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_mult();
        run_mul(1'b1, 32'hFFFF_FFFD, 32'd7, 1'b1);
        run_mul(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        // Back-to-back MFHI right after busy falls.
        aluop = 2'b10;
        funct = 6'd16;
        valid = 1'b1;
        #1;
        n_checks++;
        if (hilo_out !== 32'd1 || hilo_wb !== 1'b1) begin
            n_fail++;
            $display("FAIL mfhi_b2b: hilo_out=%h wb=%b required 00000001/1", hilo_out, hilo_wb);
        end
        funct = 6'd18;
        #1;
        n_checks++;
        if (hilo_out !== exp_lo) begin
            n_fail++;
            $display("FAIL mflo: hilo_out=%h required %h", hilo_out, exp_lo);
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            run_mul(1'($urandom), $urandom, $urandom, 1'b1);
        end
    endtask

`ifdef ALU_CTRL_MDU_DIV_EN
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input logic chk_lat);
        int lat;
        logic [63:0] r;
        issue(sgn ? 6'd26 : 6'd27, a, b);
        wait_idle(lat);
        r = ref_div(sgn, a, b);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        if (chk_lat) begin
            n_checks++;
            if (lat !== W + 1) begin
                n_fail++;
                $display("FAIL div_latency: busy cycles %0d required %0d", lat, W + 1);
            end
        end
        n_checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            n_fail++;
            $display("FAIL div_result: sgn=%b a=%h b=%h got %h_%h required %h_%h", sgn, a, b, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_div();
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_div(1'b0, 32'h0000_1234, 32'd0, 1'b1);
        run_div(1'b1, 32'hFFFF_FF00, 32'd0, 1'b0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_div(1'($urandom), $urandom, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom, 1'b1);
        end
    endtask
`else
    task automatic test_div_disabled();
        issue(6'd26, 32'hFFFF_FFF9, 32'd2);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL div_disabled_busy: busy=%b required 0", busy);
        end
        issue(6'd27, 32'h0000_1234, 32'd0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
            n_fail++;
            $display("FAIL div_disabled_hilo: busy=%b hi=%h lo=%h required 0/%h/%h", busy, hi, lo, exp_hi, exp_lo);
        end
    endtask
`endif

    task automatic test_mt();
        int lat;
        issue(6'd24, 32'd3, 32'd5);
        valid  = 1'b1;
        aluop  = 2'b10;
        funct  = 6'd19;
        rs_val = 32'hA5A5_A5A5;
        @(negedge clk);
        idle_inputs();
        wait_idle(lat);
        exp_hi = 32'd0;
        exp_lo = 32'd15;
        n_checks++;
        if (lo !== exp_lo || hi !== exp_hi) begin
            n_fail++;
            $display("FAIL mtlo_busy: hi=%h lo=%h required %h/%h", hi, lo, exp_hi, exp_lo);
        end
        issue(6'd19, 32'hA5A5_A5A5, 32'd0);
        exp_lo = 32'hA5A5_A5A5;
        n_checks++;
        if (lo !== exp_lo) begin
            n_fail++;
            $display("FAIL mtlo_idle: lo=%h required %h", lo, exp_lo);
        end
        issue(6'd17, 32'h5A5A_0001, 32'd0);
        exp_hi = 32'h5A5A_0001;
        n_checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            n_fail++;
            $display("FAIL mthi_idle: hi=%h lo=%h required %h/%h", hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset_mid();
        issue(6'd24, 32'h1234_5678, 32'h0FED_CBA9);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_mul(1'b1, 32'd6, 32'd7, 1'b1);
        n_checks++;
        if (lo !== 32'd42) begin
            n_fail++;
            $display("FAIL mul_after_reset: lo=%h required 0000002a", lo);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        idle_inputs();
        test_reset();
        test_decode();
        test_mult();
`ifdef ALU_CTRL_MDU_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_mt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_mdu.md
# alu_ctrl_mdu

Parametrised successor to the single-cycle ALU decoder. It performs the same combinational ALUOp/funct decode into a 4-bit ALU operation code, adds NOR, and adds an iterative multiply/divide unit with HI/LO registers for MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. It sits beside the main ALU in the execute path. It raises `busy` to stall the processor while a multi-cycle operation runs.

## Interface
- `WIDTH`, 32: operand, HI and LO width (≥ 8).
- `CNT_W`, $clog2(WIDTH+1): iteration counter width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `valid` in 1: the instruction on `ALUOp`/`funct` is live this cycle.
- `ALUOp` in 2: main-control ALU class.
- `funct` in 6: R-type function field.
- `rs_val` in WIDTH: first operand (dividend/multiplicand, MT source).
- `rt_val` in WIDTH: second operand (divisor/multiplier).
- `alu_control` out 4: ALU operation code, combinational.
- `hilo_wb` out 1: writeback must take `hilo_out` (MFHI/MFLO), combinational.
- `hilo_out` out WIDTH: HI for MFHI, LO for MFLO, otherwise LO.
- `busy` out 1: MDU not IDLE; the processor must hold the current instruction.
- `hi`, `lo` out WIDTH: architectural HI/LO registers.

## Operation
- Decode (combinational, independent of `valid`):
  - ALUOp 00 → 0010; 01 → 0110.
  - ALUOp 10 with funct 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001, 100111 → 1100 (NOR), 101010 → 0111.
  - Any other funct/ALUOp → 0000.
- MDU functs (ALUOp 10 only): MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
- `start` = `valid` & IDLE & MDU mult/div funct. Instructions arriving while not IDLE are ignored; `busy` guarantees they are re-presented.
- FSM states:
  - IDLE → MUL or DIV on `start`.
  - MUL/DIV → FIX when the counter reaches 0.
  - FIX → IDLE.
- Operand latch at `start`:
  - Signed ops take operand magnitudes and record `neg_q` = sign(rs)^sign(rt) and `neg_r` = sign(rs).
  - Unsigned ops latch operands raw.
- MUL: shift-add, one multiplier bit per cycle, WIDTH cycles, 2·WIDTH-bit accumulator.
- DIV: restoring, one quotient bit per cycle, WIDTH cycles.
- FIX applies sign correction and writes {HI,LO}:
  - Multiply: {HI,LO} = product.
  - Divide: LO = quotient truncated toward zero, HI = remainder carrying the dividend's sign.
- Signed MIN_INT / −1: LO = MIN_INT, HI = 0.
- Divide by zero (flag latched at `start`): LO = all ones, HI = raw `rs_val`. Latency is unchanged.
- MTHI/MTLO: when `valid` & IDLE, HI (resp. LO) ← `rs_val` at the clock edge. They are ignored while busy.
- MFHI/MFLO: `hilo_wb` = 1 and `hilo_out` = `hi`/`lo`. Only meaningful when `busy` = 0.

## Timing
- Reset: state IDLE, `busy` 0, `hi` 0, `lo` 0, counter 0, latched operands 0.
- `alu_control`, `hilo_wb` and `hilo_out` are combinational with zero latency.
- A `start` sampled at edge E sets `busy` from E through E+WIDTH+1: WIDTH iteration cycles plus 1 FIX cycle.
- HI/LO update at the edge that leaves FIX. `busy` falls at that same edge.
- An MFHI in the next cycle reads the new value.
- Reset asserted mid-operation aborts immediately: IDLE, HI/LO = 0, no partial write.
- MTHI and `start` cannot coincide, since both require a single funct.

## Configuration
- `ALU_CTRL_MDU_DIV_EN` defined: DIV state, divider datapath and divide-by-zero logic are compiled in.
- Undefined:
  - DIV/DIVU do not start, leave HI/LO unchanged and never assert `busy`.
  - The FSM has IDLE, MUL and FIX only.
  - Decode outputs are unaffected.

## Structure
- Shared package `alu_ctrl_pkg`:
  - ALU op code localparams (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_NOR).
  - funct localparams.
  - MDU state enum.
- One natural sub-module: `mdu_iter`, the iterative mul/div datapath (counter, accumulator, sign fix). The top holds decode, FSM control and HI/LO.

## Test plan
- ALUOp 00 → 0010; ALUOp 10, funct 100111 → 1100; ALUOp 11 → 0000.
- MULT rs = 0xFFFFFFFD (−3), rt = 7 → `busy` high for exactly 33 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- MULTU rs = 0xFFFFFFFF, rt = 2 → HI = 0x00000001, LO = 0xFFFFFFFE. A back-to-back MFHI gives `hilo_out` = 1, `hilo_wb` = 1.
- DIV rs = −7, rt = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU rs = 0x1234, rt = 0 → LO = 0xFFFFFFFF, HI = 0x1234, latency 33.
- MTLO 0xA5A5A5A5 while busy is ignored; repeated after `busy` falls → `lo` = 0xA5A5A5A5.
- `rst_n` pulsed low at iteration 10 of a MULT → `busy` 0 and HI/LO 0 immediately. A subsequent MULT 6×7 → LO = 42.
